// File: rtl/operand_forwarder.sv
// ID->EX operand register with EX/MEM forwarding and a one-bubble load-use stall sequence.
// Optional statistics counters are built only when OPERAND_FORWARDER_STATS_EN is defined.
module operand_forwarder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            forwarding_EX_EX1,
  input  logic            forwarding_EX_EX2,
  input  logic            forwarding_MEM_EX1,
  input  logic            forwarding_MEM_EX2,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_wb_en,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_wb_en,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            ex_valid,
  output logic            if_hold,
  output logic [31:0]     stat_stall_cycles,
  output logic [31:0]     stat_fwd_events
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t            state_q, state_d;
  logic              pend1_q, pend1_d, pend2_q, pend2_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic              ex_valid_q, ex_valid_d;
  logic              use_ex1, use_ex2, use_mem1, use_mem2;
  logic [XLEN-1:0]   sel1, sel2;

  // A forwarding flag only counts when the producing stage actually writes back.
  assign use_ex1  = forwarding_EX_EX1  & ex_wb_en;
  assign use_ex2  = forwarding_EX_EX2  & ex_wb_en;
  assign use_mem1 = forwarding_MEM_EX1 & mem_wb_en;
  assign use_mem2 = forwarding_MEM_EX2 & mem_wb_en;

  assign sel1 = use_ex1 ? ex_result : (use_mem1 ? mem_rdata : id_rs1_data);
  assign sel2 = use_ex2 ? ex_result : (use_mem2 ? mem_rdata : id_rs2_data);

  assign if_hold = (state_q == RUN) & id_valid & stall;

  always_comb begin
    state_d    = state_q;
    pend1_d    = pend1_q;
    pend2_d    = pend2_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ex_valid_d = 1'b0;
    case (state_q)
      RUN: begin
        if (id_valid && stall) begin
          pend1_d = forwarding_MEM_EX1;
          pend2_d = forwarding_MEM_EX2;
          op1_d   = '0;
          op2_d   = '0;
          state_d = BUBBLE;
        end else if (id_valid) begin
          op1_d      = sel1;
          op2_d      = sel2;
          ex_valid_d = 1'b1;
        end
      end
      BUBBLE: begin
        // Live stall/forward flags are ignored here so the held instruction issues exactly once.
        op1_d      = pend1_q ? mem_rdata : id_rs1_data;
        op2_d      = pend2_q ? mem_rdata : id_rs2_data;
        ex_valid_d = 1'b1;
        pend1_d    = 1'b0;
        pend2_d    = 1'b0;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign ex_valid = ex_valid_q;

`ifdef OPERAND_FORWARDER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [1:0]  fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = 2'd0;
    if (state_q == BUBBLE)
      fwd_inc = {1'b0, pend1_q} + {1'b0, pend2_q};
    else if (id_valid && !stall)
      fwd_inc = {1'b0, use_ex1 | use_mem1} + {1'b0, use_ex2 | use_mem2};
  end

  assign fwd_sum     = {1'b0, fwd_cnt_q} + {31'd0, fwd_inc};
  assign fwd_cnt_d   = fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
  assign stall_cnt_d = (if_hold && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_fwd_events   = fwd_cnt_q;
`else
  assign stat_stall_cycles = 32'd0;
  assign stat_fwd_events   = 32'd0;
`endif

endmodule

// File: tb/tb_operand_forwarder.sv
// Directed self-checking bench for operand_forwarder: forwarding priority, load-use bubble, reset in BUBBLE.
module tb_operand_forwarder;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, stall, id_valid, ex_wb_en, mem_wb_en;
  logic            f_ex1, f_ex2, f_mem1, f_mem2;
  logic [XLEN-1:0] rs1, rs2, ex_result, mem_rdata;
  logic [XLEN-1:0] op1, op2;
  logic            ex_valid, if_hold;
  logic [31:0]     stat_stall, stat_fwd;

  int n_cmp = 0;
  int n_err = 0;

  operand_forwarder #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .forwarding_EX_EX1(f_ex1), .forwarding_EX_EX2(f_ex2),
    .forwarding_MEM_EX1(f_mem1), .forwarding_MEM_EX2(f_mem2),
    .id_valid(id_valid), .id_rs1_data(rs1), .id_rs2_data(rs2),
    .ex_result(ex_result), .ex_wb_en(ex_wb_en),
    .mem_rdata(mem_rdata), .mem_wb_en(mem_wb_en),
    .op1(op1), .op2(op2), .ex_valid(ex_valid), .if_hold(if_hold),
    .stat_stall_cycles(stat_stall), .stat_fwd_events(stat_fwd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef OPERAND_FORWARDER_STATS_EN
  function automatic logic [31:0] st(input logic [31:0] v); return v; endfunction
`else
  function automatic logic [31:0] st(input logic [31:0] v); return (v & 32'd0); endfunction
`endif

  initial begin
    rst = 1; stall = 0; id_valid = 0; ex_wb_en = 0; mem_wb_en = 0;
    f_ex1 = 0; f_ex2 = 0; f_mem1 = 0; f_mem2 = 0;
    rs1 = '0; rs2 = '0; ex_result = '0; mem_rdata = '0;
    tick(); tick();
    rst = 0;
    check("rst_op1", op1, 32'd0);
    check("rst_op2", op2, 32'd0);
    check("rst_ev", {31'd0, ex_valid}, 32'd0);
    check("rst_hold", {31'd0, if_hold}, 32'd0);
    check("rst_stat_stall", stat_stall, 32'd0);
    check("rst_stat_fwd", stat_fwd, 32'd0);

    // plain issue
    id_valid = 1; rs1 = 32'd5; rs2 = 32'd7;
    #1 check("plain_hold", {31'd0, if_hold}, 32'd0);
    tick();
    check("plain_op1", op1, 32'd5);
    check("plain_op2", op2, 32'd7);
    check("plain_ev", {31'd0, ex_valid}, 32'd1);

    // EX->EX on rs2
    f_ex2 = 1; ex_wb_en = 1; ex_result = 32'h1234;
    tick();
    check("exfwd_op2", op2, 32'h1234);
    check("exfwd_op1", op1, 32'd5);
    ex_wb_en = 0;
    tick();
    check("exfwd_nowb_op2", op2, 32'd7);

    // EX beats MEM on rs1; MEM-only on rs2
    f_ex2 = 0; f_ex1 = 1; f_mem1 = 1; f_mem2 = 1;
    ex_wb_en = 1; mem_wb_en = 1; ex_result = 32'd1; mem_rdata = 32'd2;
    tick();
    check("prio_op1", op1, 32'd1);
    check("memfwd_op2", op2, 32'd2);

    // MEM flag ignored without mem_wb_en
    f_ex1 = 0; f_mem2 = 0; mem_wb_en = 0; rs1 = 32'h55;
    tick();
    check("mem_nowb_op1", op1, 32'h55);

    // no valid instruction: stall ignored, operands held
    id_valid = 0; stall = 1; f_mem1 = 0; rs1 = 32'h99; rs2 = 32'h98;
    #1 check("idle_hold", {31'd0, if_hold}, 32'd0);
    tick();
    check("idle_ev", {31'd0, ex_valid}, 32'd0);
    check("idle_op1", op1, 32'h55);
    check("idle_op2", op2, 32'd7);

    // reset to zero stats, then load-use with stall held through BUBBLE
    stall = 0; rst = 1; ex_wb_en = 0;
    tick();
    rst = 0;
    id_valid = 1; stall = 1; f_mem1 = 1; mem_wb_en = 1; rs1 = 32'h11; rs2 = 32'h22; mem_rdata = 32'h0;
    #1 check("lu_hold", {31'd0, if_hold}, 32'd1);
    tick();
    check("lu_bub_ev", {31'd0, ex_valid}, 32'd0);
    check("lu_bub_op1", op1, 32'd0);
    check("lu_bub_hold", {31'd0, if_hold}, 32'd0);
    mem_rdata = 32'hCAFE; f_mem1 = 0;
    tick();
    check("lu_op1", op1, 32'hCAFE);
    check("lu_op2", op2, 32'h22);
    check("lu_ev", {31'd0, ex_valid}, 32'd1);
    check("lu_stat_stall", stat_stall, st(32'd1));
    check("lu_stat_fwd", stat_fwd, st(32'd1));

    // back-to-back stalls, no pending forwards
    rs1 = 32'h33; rs2 = 32'h44;
    #1 check("b2b_hold1", {31'd0, if_hold}, 32'd1);
    tick();
    check("b2b_bub1", {31'd0, ex_valid}, 32'd0);
    tick();
    check("b2b_iss1", {31'd0, ex_valid}, 32'd1);
    check("b2b_op1", op1, 32'h33);
    check("b2b_hold2", {31'd0, if_hold}, 32'd1);
    tick();
    check("b2b_bub2", {31'd0, ex_valid}, 32'd0);
    stall = 0;
    tick();
    check("b2b_iss2", {31'd0, ex_valid}, 32'd1);
    check("b2b_op2", op2, 32'h44);
    check("b2b_stat_stall", stat_stall, st(32'd3));
    check("b2b_stat_fwd", stat_fwd, st(32'd1));

    // reset while in BUBBLE drops the pending instruction
    stall = 1; f_mem2 = 1;
    tick();
    check("rb_bub_ev", {31'd0, ex_valid}, 32'd0);
    rst = 1; mem_rdata = 32'hBEEF;
    tick();
    rst = 0; f_mem2 = 0;
    check("rb_ev", {31'd0, ex_valid}, 32'd0);
    check("rb_op1", op1, 32'd0);
    check("rb_op2", op2, 32'd0);
    check("rb_stat_stall", stat_stall, 32'd0);
    #1 check("rb_fresh_hold", {31'd0, if_hold}, 32'd1);
    tick();
    check("rb_fresh_ev", {31'd0, ex_valid}, 32'd0);
    stall = 0;
    tick();
    check("rb_fresh_iss", {31'd0, ex_valid}, 32'd1);
    check("rb_fresh_op2", op2, 32'h44);
    check("rb_fresh_stat", stat_stall, st(32'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_forwarder.md
# operand_forwarder

Consumer of the hazard detector's `stall` and forwarding flags, sitting on the ID→EX boundary of the pipelined RV32 core. It registers the two ALU operands for the instruction leaving decode and selects each operand from the register file, the EX-stage result, or the MEM-stage load data. On a load-use stall it runs a two-state sequence: it freezes fetch/decode, injects one EX bubble, then issues the held instruction with the load data forwarded in.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  load-use hazard flag for the decode instruction.
- `forwarding_EX_EX1`, `forwarding_EX_EX2`  in  1  rs1 / rs2 take the EX result.
- `forwarding_MEM_EX1`, `forwarding_MEM_EX2`  in  1  rs1 / rs2 take the MEM load data.
- `id_valid`  in  1  decode holds a real instruction.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `ex_result`  in  XLEN  ALU result of the instruction currently in EX.
- `ex_wb_en`  in  1  EX instruction writes a register.
- `mem_rdata`  in  XLEN  load data of the instruction currently in MEM.
- `mem_wb_en`  in  1  MEM instruction writes a register.
- `op1`, `op2`  out  XLEN  registered operands to EX.
- `ex_valid`  out  1  registered; 0 means EX holds a bubble.
- `if_hold`  out  1  combinational; freezes PC and the IF/ID register.
- `stat_stall_cycles`, `stat_fwd_events`  out  32  statistics counters (see Configuration).

## Operation
- FSM states: RUN and BUBBLE. Reset state is RUN.
- Operand select, per source, in priority order:
  1. EX flag set and `ex_wb_en` → `ex_result`.
  2. MEM flag set and `mem_wb_en` → `mem_rdata`.
  3. Otherwise → `id_rsN_data`.
- A flag whose matching wb_en is low is ignored, and the operand falls back to register data.
- Both EX and MEM flags set for one source → EX wins.
- RUN, `id_valid`=0:
  - `ex_valid`←0; `op1`/`op2` hold their previous values.
  - `stall` is ignored.
- RUN, `id_valid`=1, `stall`=0:
  - `op1`/`op2` ← selected values; `ex_valid`←1.
- RUN, `id_valid`=1, `stall`=1:
  - `if_hold`=1 this cycle.
  - Latch the pending MEM flags (`pend1`←`forwarding_MEM_EX1`, `pend2`←`forwarding_MEM_EX2`).
  - `ex_valid`←0; `op1`/`op2`←0; go to BUBBLE.
- BUBBLE:
  - `if_hold`=0. Decode inputs still present the same held instruction.
  - `op1` ← `mem_rdata` if `pend1`, else `id_rs1_data`. `op2` likewise with `pend2`.
  - `ex_valid`←1; clear `pend1`/`pend2`; go to RUN.
  - `stall` and all live forwarding flags are ignored in this state, so the same instruction cannot be stalled twice.
- `if_hold` = (state==RUN) & `id_valid` & `stall`. It is never asserted in BUBBLE.

## Timing
- Reset values: `op1`=0, `op2`=0, `ex_valid`=0, state RUN, `pend1`=`pend2`=0, both stats counters 0. `if_hold` evaluates to 0 while the state is RUN and `stall`=0.
- Latency: decode inputs are sampled at edge N, and operands are visible to EX after edge N.
- A load-use instruction reaches EX 2 cycles after first presentation instead of 1, giving exactly one bubble cycle.
- Back-to-back stalls (next instruction also load-use): RUN→BUBBLE→RUN→BUBBLE. Each stall yields exactly one bubble.
- `rst` asserted in BUBBLE: the pending instruction is dropped, the FSM returns to RUN, `ex_valid`=0 on the next cycle, and the pending flags are cleared.
- `rst` has priority over every other input in the same cycle.

## Configuration
- `OPERAND_FORWARDER_STATS_EN` defined:
  - `stat_stall_cycles` increments on every RUN→BUBBLE transition.
  - `stat_fwd_events` increments by the number of operands (0, 1 or 2) that actually took a forwarded value when `ex_valid`←1.
  - Both counters saturate at 32'hFFFFFFFF and clear on `rst`.
- Macro undefined: both ports are tied to 0 and no counter logic is built.
- Operand behaviour is identical in both builds.

## Test plan
- Reset then no-hazard issue: `id_rs1_data`=5, `id_rs2_data`=7, no flags → next cycle `op1`=5, `op2`=7, `ex_valid`=1, `if_hold`=0.
- EX→EX forward: `forwarding_EX_EX2`=1, `ex_wb_en`=1, `ex_result`=32'h1234 → `op2`=32'h1234. Same stimulus with `ex_wb_en`=0 → `op2`=`id_rs2_data`.
- Priority: `forwarding_EX_EX1`=`forwarding_MEM_EX1`=1, `ex_result`=1, `mem_rdata`=2, both wb_en high → `op1`=1.
- Load-use: `stall`=1 with `forwarding_MEM_EX1`=1 → `if_hold`=1 for that single cycle and `ex_valid`=0 the next cycle. With `mem_rdata`=32'hCAFE during BUBBLE, the cycle after that has `op1`=32'hCAFE, `ex_valid`=1, and (stats build) `stat_stall_cycles`=1, `stat_fwd_events`=1.
- `stall` held high through BUBBLE → exactly one bubble, no second `if_hold` pulse.
- `rst` during BUBBLE → next cycle `ex_valid`=0, `op1`=0, `op2`=0, FSM in RUN; a following `stall` starts a fresh stall sequence.
